// File: rtl/b_to_bcd.sv
// 4-bit binary to 5-bit BCD converter: a combinational double-dabble network
// feeding one output register, so the result appears one cycle after b.
module b_to_bcd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] b,
  output logic [4:0] bcd
);

  logic [8:0] scratch;
  logic [4:0] bcd_next;

  // The scratch word holds {tens, ones, b}. Each pass moves one bit of b up
  // into the BCD field. The ones nibble is corrected before every shift after
  // the first. It is at most 7 when corrected, so the sum fits in 4 bits.
  always_comb begin
    scratch = {5'b0_0000, b};
    for (int i = 0; i < 4; i++) begin
      if ((i > 0) && (scratch[7:4] >= 4'd5))
        scratch[7:4] = scratch[7:4] + 4'd3;
      scratch = {scratch[7:0], 1'b0};
    end
    bcd_next = scratch[8:4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bcd <= 5'b0_0000;
    else
      bcd <= bcd_next;
  end

endmodule

// File: tb/tb_b_to_bcd.sv
// Self-checking bench for b_to_bcd. An arithmetic reference model is checked
// on every cycle, together with directed literal checks and random stimulus.
module tb_b_to_bcd;

  logic       clk;
  logic       rst_n;
  logic [3:0] b;
  logic [4:0] bcd;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Reference model state: the expected bcd and the operand it came from.
  logic [4:0] exp_q;
  int         prev_b;
  bit         have_prev;

  b_to_bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .b     (b),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] conv(input int v);
    int tens;
    int ones;
    tens = (v >= 10) ? 1 : 0;
    ones = v % 10;
    return {tens[0], ones[3:0]};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= 5'b0;
      have_prev <= 1'b0;
    end else begin
      exp_q     <= conv(int'(b));
      prev_b    <= int'(b);
      have_prev <= 1'b1;
    end
  end

  // Compare process: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model", bcd, exp_q);
      if (rst_n && have_prev) begin
        chk_int("ones_le_9", int'(bcd[3:0] > 4'd9), 0);
        chk_int("value_eq_prev_b", int'(bcd[4]) * 10 + int'(bcd[3:0]), prev_b);
      end
    end
  end

  logic [4:0] map [16];
  logic [3:0] b2b_in  [4];
  logic [4:0] b2b_exp [4];

  initial begin
    map[0]  = 5'b00000; map[1]  = 5'b00001; map[2]  = 5'b00010; map[3]  = 5'b00011;
    map[4]  = 5'b00100; map[5]  = 5'b00101; map[6]  = 5'b00110; map[7]  = 5'b00111;
    map[8]  = 5'b01000; map[9]  = 5'b01001; map[10] = 5'b10000; map[11] = 5'b10001;
    map[12] = 5'b10010; map[13] = 5'b10011; map[14] = 5'b10100; map[15] = 5'b10101;
    b2b_in[0] = 4'd9;  b2b_exp[0] = 5'b01001;
    b2b_in[1] = 4'd10; b2b_exp[1] = 5'b10000;
    b2b_in[2] = 4'd0;  b2b_exp[2] = 5'b00000;
    b2b_in[3] = 4'd15; b2b_exp[3] = 5'b10101;

    // Reset with b = 15: the output is 0 at once.
    rst_n = 1'b0;
    b     = 4'hF;
    #1;
    chk("reset_immediate", bcd, 5'b00000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", bcd, 5'b00000);
    chk_en = 1;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_after_reset", bcd, 5'b10101);

    // Exhaustive sweep, with each value held for 5 cycles.
    for (int v = 0; v < 16; v++) begin
      b = v[3:0];
      repeat (5) @(posedge clk);
      #1;
      chk($sformatf("sweep_%0d", v), bcd, map[v]);
    end

    // Back-to-back values on consecutive edges.
    for (int i = 0; i < 4; i++) begin
      b = b2b_in[i];
      @(posedge clk); #1;
      chk($sformatf("b2b_%0d", i), bcd, b2b_exp[i]);
    end

    // Decade boundary, in both directions.
    b = 4'd9;  @(posedge clk); #1; chk("dec_9",     bcd, 5'b01001);
    b = 4'd10; @(posedge clk); #1; chk("dec_9_10",  bcd, 5'b10000);
    b = 4'd9;  @(posedge clk); #1; chk("dec_10_9",  bcd, 5'b01001);

    // Mid-stream reset.
    b = 4'd12; @(posedge clk); #1; chk("pre_reset_12", bcd, 5'b10010);
    b = 4'd5;
    #2 rst_n = 1'b0;
    #1 chk("midstream_async_clear", bcd, 5'b00000);
    @(posedge clk); #1;
    chk("midstream_discard", bcd, 5'b00000);
    b = 4'd3;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_release_3", bcd, 5'b00011);

    // Held input: the output must stay stable.
    b = 4'd14;
    repeat (4) begin
      @(posedge clk); #1;
      chk("hold_14", bcd, 5'b10100);
    end

    // Random stream with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk("rand_reset_clear", bcd, 5'b00000);
        #1 rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end

    @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
